spi_sensor_slave: RTL and testbench
===================================

# spi_sensor_slave

SPI responder that emulates the 13-bit serial sensor read by the team's SPI master, for on-board loopback and bench self-test. It samples the master's `sck`/`nCS` in its own `clk` domain, loads a 16-bit frame {data[12:0], 3'b000} at chip-select assertion and drives it MSB-first on `miso`. It sits between a local data source (`Din`/`din_valid`) and the SPI pins, and it flags malformed frames.

## Interface
- `DATA_W`, 13: payload bits per frame, MSB first.
- `PAD_W`, 3: trailing zero bits; frame length is `DATA_W+PAD_W` (16).
- `clk` input 1: system clock. Reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `nCS` input 1: chip select from master, active low, asynchronous to `clk`.
- `sck` input 1: SPI clock from master, idles low, may run free while `nCS` is high, asynchronous.
- `miso` output 1: serial data to master.
- `Din` input `DATA_W`: next payload word.
- `din_valid` input 1: one-cycle strobe that captures `Din` into the holding register.
- `busy` output 1: high while a frame is in progress.
- `frame_done` output 1: one-cycle pulse when a frame ends with exactly 16 `sck` rising edges.
- `frame_err` output 1: one-cycle pulse when a frame ends with any other edge count.

## Operation
- **Synchronizers:** `nCS` and `sck` each pass through 2 FFs, then 1 delay FF for edge detection. `nCS` resets to 1 in all stages; `sck` resets to 0.
- **Holding register:** `hold` (DATA_W) loads `Din` on `din_valid`, at any time including mid-frame. Reset value is 0.
- **States:** IDLE and SHIFT.
  - IDLE -> SHIFT on synced `nCS` falling. In the same cycle: `shr <= {hold, PAD_W'b0}`, `rise_cnt <= 0`.
  - If `din_valid` coincides with the load, the new `Din` is loaded into `shr` and `hold`.
- **In SHIFT:**
  - On each synced `sck` rising: `rise_cnt` increments, saturating at 31.
  - On each synced `sck` falling with `rise_cnt >= 1`: `shr <= {shr[14:0], 1'b0}`.
  - Falling edges seen before the first rising edge do not shift.
- SHIFT -> IDLE on synced `nCS` rising:
  - Pulse `frame_done` if `rise_cnt == 16`, else pulse `frame_err`.
  - A `sck` falling edge in the same cycle is ignored.
- **`miso`** is `shr[15]` in SHIFT and 0 in IDLE. It is driven, never tristated.
- **`busy`** is 1 exactly in SHIFT.
- **`rst`** in any state:
  - Forces IDLE and clears `shr`, `rise_cnt`, `hold`.
  - `busy`, `frame_done`, `frame_err`, `miso` are 0 in the cycle after `rst` is sampled high.
  - A frame in progress is abandoned with no done/err pulse.
  - After reset deasserts, a frame whose `nCS` is already low is not joined; the block waits for the next synced falling edge.

## Timing
- Required `clk` frequency is at least 8x the `sck` frequency.
- The master must provide at least 4 `clk` cycles from `nCS` falling to the first `sck` rising.
- `shr` loads 3 `clk` edges after `nCS` falls at the pin (2 sync + 1 edge detect). `miso` shows bit 15 from then on.
- `miso` changes 3 `clk` edges after each `sck` falling at the pin, so it is stable before the next `sck` rising.
- `frame_done`/`frame_err` are asserted in the cycle after the synced `nCS` rising is detected, i.e. 4 `clk` edges after the pin edge. They are 1 cycle wide.
- `busy` rises and falls 3 `clk` edges after the respective `nCS` pin edge.
- Back-to-back frames need `nCS` high for at least 3 `clk` cycles. Shorter gaps are not required to be detected.

## Test plan
- **Nominal frame:** reset; `din_valid` with `Din=13'h1ABC`; master frame with 16 `sck` rising edges (period 16 clk) -> master shift register reads 16'hD5E0; one `frame_done` pulse; `frame_err` stays 0.
- **Free-running `sck`:** `sck` toggles continuously and `nCS` is low for exactly 16 rising edges; `Din=13'h0001` -> bit pattern 0x0008 received; no shift before the first rising edge.
- **Short frame:** `nCS` high after 12 rising edges -> `frame_err` pulse, no `frame_done`; the next 16-edge frame with `hold=13'h1FFF` returns 16'hFFF8 and `frame_done`.
- **Data update mid-frame:** `din_valid` with `13'h0AAA` during a frame sending `13'h1555` -> current frame returns 16'hAAA8; the next frame returns 16'h5550.
- **Reset mid-frame:** `rst` for 1 cycle after 7 rising edges -> `busy`=0, `miso`=0, `hold`=0, no done/err pulse; next full frame returns 16'h0000 with `frame_done`.
- **Idle behaviour:** `nCS` held high with `sck` toggling for 200 cycles -> `miso`=0, `busy`=0, no pulses.

Source files
------------

// File: rtl/spi_sensor_slave.sv
// SPI responder emulating the 13-bit serial sensor.
// It synchronises the master's nCS and sck into the clk domain. At chip-select
// assertion it loads the frame {data, zero pad}, then shifts it out MSB-first on
// miso. At chip-select release it reports whether exactly one full frame of
// sck rising edges was seen.
module spi_sensor_slave #(
    parameter int DATA_W = 13,
    parameter int PAD_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nCS,
    input  logic              sck,
    output logic              miso,
    input  logic [DATA_W-1:0] Din,
    input  logic              din_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int FRAME_W = DATA_W + PAD_W;
    localparam int CNT_W   = 5;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);

    logic               r_ncs_s1, r_ncs_s2, r_ncs_d;
    logic               r_sck_s1, r_sck_s2, r_sck_d;
    logic [1:0]         r_vld;
    logic               r_armed;
    logic [0:0]         r_state;
    logic [FRAME_W-1:0] r_shr;
    logic [CNT_W-1:0]   r_rise_cnt;
    logic [DATA_W-1:0]  r_hold;
    logic               r_fin, r_fin_ok;
    logic               r_done, r_err;

    logic               w_ncs_fall, w_ncs_rise;
    logic               w_sck_rise, w_sck_fall;
    logic [DATA_W-1:0]  w_next_word;

    // Two-stage synchronisers plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ncs_s1 <= 1'b1;
            r_ncs_s2 <= 1'b1;
            r_ncs_d  <= 1'b1;
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_d  <= 1'b0;
        end else begin
            r_ncs_s1 <= nCS;
            r_ncs_s2 <= r_ncs_s1;
            r_ncs_d  <= r_ncs_s2;
            r_sck_s1 <= sck;
            r_sck_s2 <= r_sck_s1;
            r_sck_d  <= r_sck_s2;
        end
    end

    // Arm the frame start only after a genuine synced-high nCS has been seen,
    // so a chip select that is already low when reset releases is not joined
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_vld <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_ncs_s2)
                r_armed <= 1'b1;
        end
    end

    assign w_ncs_fall  = r_armed & r_ncs_d & ~r_ncs_s2;
    assign w_ncs_rise  = ~r_ncs_d & r_ncs_s2;
    assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_d;
    assign w_next_word = din_valid ? Din : r_hold;

    // Holding register for the next payload word, updated at any time
    always_ff @(posedge clk) begin
        if (rst)
            r_hold <= '0;
        else if (din_valid)
            r_hold <= Din;
    end

    // Frame FSM: load at chip-select assertion, count rises, shift on falls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shr      <= '0;
            r_rise_cnt <= '0;
            r_fin      <= 1'b0;
            r_fin_ok   <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ncs_fall) begin
                        r_state    <= ST_SHIFT;
                        r_shr      <= {w_next_word, {PAD_W{1'b0}}};
                        r_rise_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_ncs_rise) begin
                        r_state  <= ST_IDLE;
                        r_fin    <= 1'b1;
                        r_fin_ok <= (r_rise_cnt == FULL_CNT);
                    end else begin
                        if (w_sck_rise && (r_rise_cnt != '1))
                            r_rise_cnt <= r_rise_cnt + 1'b1;
                        if (w_sck_fall && (r_rise_cnt != '0))
                            r_shr <= {r_shr[FRAME_W-2:0], 1'b0};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // End-of-frame status pulses, one cycle after the FSM returns to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= r_fin & r_fin_ok;
            r_err  <= r_fin & ~r_fin_ok;
        end
    end

    assign busy       = (r_state == ST_SHIFT);
    assign miso       = busy & r_shr[FRAME_W-1];
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_spi_sensor_slave.sv
// Self-checking bench for spi_sensor_slave: directed scenarios plus randomized
// frames compared against a simple model of the holding register and frame bits.
module tb_spi_sensor_slave;

    logic        clk = 1'b0;
    logic        rst, nCS, sck, sck_man, sck_free, free_run, din_valid;
    logic [12:0] Din;
    logic        miso, busy, frame_done, frame_err;

    always #5 clk = ~clk;

    assign sck = free_run ? sck_free : sck_man;

    spi_sensor_slave #(.DATA_W(13), .PAD_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .nCS        (nCS),
        .sck        (sck),
        .miso       (miso),
        .Din        (Din),
        .din_valid  (din_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: counts done/err pulses and any pulse wider than 1 cycle
    int   n_done = 0, n_err = 0, n_wide = 0;
    logic prev_d = 1'b0, prev_e = 1'b0;
    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
        if ((frame_done && prev_d) || (frame_err && prev_e)) n_wide++;
        prev_d = frame_done;
        prev_e = frame_err;
    end

    // Free-running sck source: period 8 clk
    initial begin
        sck_free = 1'b0;
        forever begin
            repeat (4) @(negedge clk);
            sck_free = ~sck_free;
        end
    end

    // Reference model state: the word the slave will send next
    logic [12:0] m_hold = '0;

    task automatic load_din(input logic [12:0] v);
        @(negedge clk);
        Din = v; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        m_hold = v;
    endtask

    // One master frame with n rising edges and half-period hp clk cycles.
    // upd_edge >= 0 pulses din_valid during that edge's high phase;
    // coin pulses din_valid in the very cycle the slave loads its frame.
    task automatic frame(input string tag, input int n, input int hp, input int upd_edge,
                         input logic [12:0] upd_val, input logic coin, input logic [12:0] coin_val);
        logic [15:0] exp_frame, rx, exp_rx;
        int d0, e0;
        @(negedge clk);
        nCS = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (coin && k == 1) begin
                Din = coin_val; din_valid = 1'b1;
            end else
                din_valid = 1'b0;
        end
        if (coin) m_hold = coin_val;
        exp_frame = {m_hold, 3'b000};
        check({tag, "_busy_hi"}, 32'(busy), 32'd1);
        rx = '0; exp_rx = '0;
        for (int i = 0; i < n; i++) begin
            rx     = {rx[14:0], miso};
            exp_rx = {exp_rx[14:0], (i < 16) ? exp_frame[15-i] : 1'b0};
            sck_man = 1'b1;
            for (int k = 0; k < hp; k++) begin
                @(negedge clk);
                if (i == upd_edge && k == 0) begin
                    Din = upd_val; din_valid = 1'b1;
                end else
                    din_valid = 1'b0;
            end
            sck_man = 1'b0;
            repeat (hp) @(negedge clk);
        end
        if (upd_edge >= 0 && upd_edge < n) m_hold = upd_val;
        repeat (2) @(negedge clk);
        d0 = n_done; e0 = n_err;
        nCS = 1'b1;
        repeat (8) @(negedge clk);
        check({tag, "_rx"},      32'(rx), 32'(exp_rx));
        check({tag, "_done"},    32'(n_done - d0), (n == 16) ? 32'd1 : 32'd0);
        check({tag, "_err"},     32'(n_err - e0),  (n == 16) ? 32'd0 : 32'd1);
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0, e0, bad;
        logic [15:0] rx;
        rst = 1'b1; nCS = 1'b1; sck_man = 1'b0; free_run = 1'b0;
        din_valid = 1'b0; Din = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err",  32'(frame_err), 32'd0);
        repeat (4) @(negedge clk);

        // Nominal frame: 1ABC -> D5E0
        load_din(13'h1ABC);
        check("nominal_model", 32'({m_hold, 3'b000}), 32'h0000D5E0);
        frame("nominal", 16, 8, -1, '0, 1'b0, '0);

        // Short frame, then full frame of all ones
        frame("short", 12, 5, -1, '0, 1'b0, '0);
        load_din(13'h1FFF);
        frame("full_ones", 16, 4, -1, '0, 1'b0, '0);

        // Data update mid-frame affects only the next frame
        load_din(13'h1555);
        frame("midupd_a", 16, 5, 7, 13'h0AAA, 1'b0, '0);
        frame("midupd_b", 16, 5, -1, '0, 1'b0, '0);

        // Reset mid-frame after 7 rising edges
        load_din(13'h1234);
        @(negedge clk);
        nCS = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            sck_man = 1'b1; repeat (5) @(negedge clk);
            sck_man = 1'b0; repeat (5) @(negedge clk);
        end
        d0 = n_done; e0 = n_err;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hold = '0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_miso", 32'(miso), 32'd0);
        for (int i = 0; i < 3; i++) begin
            sck_man = 1'b1; repeat (5) @(negedge clk);
            sck_man = 1'b0; repeat (5) @(negedge clk);
        end
        check("rstmid_nojoin", 32'(busy), 32'd0);
        nCS = 1'b1;
        repeat (10) @(negedge clk);
        check("rstmid_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        frame("after_rst", 16, 6, -1, '0, 1'b0, '0);

        // Free-running sck: nCS drops just after a rise, so a fall precedes the first rise
        load_din(13'h0001);
        free_run = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge sck_free);
        @(negedge clk);
        nCS = 1'b0;
        rx = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge sck_free);
            rx = {rx[14:0], miso};
        end
        @(negedge sck_free);
        d0 = n_done; e0 = n_err;
        nCS = 1'b1;
        repeat (8) @(negedge clk);
        check("free_rx",   32'(rx), 32'h00000008);
        check("free_done", 32'(n_done - d0), 32'd1);
        check("free_err",  32'(n_err - e0), 32'd0);

        // Idle: sck toggling with nCS high
        d0 = n_done; e0 = n_err; bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (miso || busy) bad++;
        end
        check("idle_outputs", 32'(bad), 32'd0);
        check("idle_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        free_run = 1'b0;
        repeat (6) @(negedge clk);

        // Randomized frames
        for (int t = 0; t < 30; t++) begin
            int n, hp, upd;
            logic cn;
            if ($urandom_range(0, 1) == 1) load_din(13'($urandom));
            n   = ($urandom_range(0, 1) == 1) ? 16 : int'($urandom_range(1, 34));
            hp  = int'($urandom_range(4, 7));
            upd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            cn  = ($urandom_range(0, 4) == 0);
            frame($sformatf("rand%0d", t), n, hp, upd, 13'($urandom), cn, 13'($urandom));
        end

        check("pulse_width", 32'(n_wide), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
